// File: rtl/block_checker_stack.sv
// Streaming begin/end (optionally fork/join) nesting checker with a depth-limited kind stack.
// Define FORK_JOIN_EN to recognise fork/join and track block kinds per nesting level.
module block_checker_stack #(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned DW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in,
    input  logic          in_valid,
    output logic          result,
    output logic [DW-1:0] depth,
    output logic          error,
    output logic [1:0]    err_code
);

    typedef enum logic [4:0] {
        SEP,
        B1, B2, B3, B4, B5,
        E1, E2, E3,
`ifdef FORK_JOIN_EN
        F1, F2, F3, F4,
        J1, J2, J3, J4,
`endif
        OTHER
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_UNDER = 2'd1,
        ERR_OVER  = 2'd2,
        ERR_KIND  = 2'd3
    } err_t;

    state_t        state_q, state_d;
    err_t          err_q, err_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          result_q, result_d;
    logic          error_q, error_d;
    logic [7:0]    ch;
    logic          is_space;
    logic          open_blk, close_blk;
`ifdef FORK_JOIN_EN
    logic [DEPTH-1:0] kind_q, kind_d;
    logic             top_kind;
`endif

    always_comb begin
        ch       = (in >= 8'h41 && in <= 8'h5A) ? (in | 8'h20) : in;
        is_space = in_valid && (in == 8'h20);
        state_d  = state_q;
        if (in_valid) begin
            if (in == 8'h20) begin
                state_d = SEP;
            end else begin
                case (state_q)
                    SEP: begin
                        case (ch)
                            8'h62:   state_d = B1;
                            8'h65:   state_d = E1;
`ifdef FORK_JOIN_EN
                            8'h66:   state_d = F1;
                            8'h6A:   state_d = J1;
`endif
                            default: state_d = OTHER;
                        endcase
                    end
                    B1: state_d = (ch == 8'h65) ? B2 : OTHER;
                    B2: state_d = (ch == 8'h67) ? B3 : OTHER;
                    B3: state_d = (ch == 8'h69) ? B4 : OTHER;
                    B4: state_d = (ch == 8'h6E) ? B5 : OTHER;
                    E1: state_d = (ch == 8'h6E) ? E2 : OTHER;
                    E2: state_d = (ch == 8'h64) ? E3 : OTHER;
`ifdef FORK_JOIN_EN
                    F1: state_d = (ch == 8'h6F) ? F2 : OTHER;
                    F2: state_d = (ch == 8'h72) ? F3 : OTHER;
                    F3: state_d = (ch == 8'h6B) ? F4 : OTHER;
                    J1: state_d = (ch == 8'h6F) ? J2 : OTHER;
                    J2: state_d = (ch == 8'h69) ? J3 : OTHER;
                    J3: state_d = (ch == 8'h6E) ? J4 : OTHER;
`endif
                    // complete keywords followed by more letters become plain words
                    default: state_d = OTHER;
                endcase
            end
        end
    end

    always_comb begin
        depth_d = depth_q;
        err_d   = err_q;
`ifdef FORK_JOIN_EN
        kind_d    = kind_q;
        open_blk  = (state_q == B5) || (state_q == F4);
        close_blk = (state_q == E3) || (state_q == J4);
        top_kind  = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (DW'(i + 1) == depth_q) top_kind = kind_q[i];
        end
`else
        open_blk  = (state_q == B5);
        close_blk = (state_q == E3);
`endif
        if (is_space && !error_q) begin
            if (open_blk) begin
                if (depth_q == DW'(DEPTH)) begin
                    err_d = ERR_OVER;
                end else begin
`ifdef FORK_JOIN_EN
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        if (DW'(i) == depth_q) kind_d[i] = (state_q == F4);
                    end
`endif
                    depth_d = depth_q + 1'b1;
                end
            end else if (close_blk) begin
                if (depth_q == '0) begin
                    err_d = ERR_UNDER;
`ifdef FORK_JOIN_EN
                end else if (top_kind != (state_q == J4)) begin
                    err_d = ERR_KIND;
`endif
                end else begin
                    depth_d = depth_q - 1'b1;
                end
            end
        end
        error_d  = (err_d != ERR_NONE);
        result_d = !error_d && (depth_d == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= SEP;
            depth_q  <= '0;
            err_q    <= ERR_NONE;
            error_q  <= 1'b0;
            result_q <= 1'b1;
`ifdef FORK_JOIN_EN
            kind_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            depth_q  <= depth_d;
            err_q    <= err_d;
            error_q  <= error_d;
            result_q <= result_d;
`ifdef FORK_JOIN_EN
            kind_q   <= kind_d;
`endif
        end
    end

    assign result   = result_q;
    assign depth    = depth_q;
    assign error    = error_q;
    assign err_code = err_q;

endmodule
